// File: rtl/io_pkg.sv
// Shared register map, status bit positions and PS/2 receiver states.
package io_pkg;

    localparam int unsigned REG_DATA_OFS   = 0;
    localparam int unsigned REG_STATUS_OFS = 1;

    localparam int unsigned ST_NONEMPTY = 0;
    localparam int unsigned ST_FULL     = 1;
    localparam int unsigned ST_OVERFLOW = 2;
    localparam int unsigned ST_ERR      = 3;

    localparam int unsigned CTRL_FLUSH   = 0;
    localparam int unsigned CTRL_CLR_OVF = 2;
    localparam int unsigned CTRL_CLR_ERR = 3;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, frame FSM and idle timeout.
module ps2_rx
    import io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       err_strobe
);

    localparam int unsigned         TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic clk_s1, clk_s2, clk_s3;
    logic data_s1, data_s2;
    logic fall_c;

    rx_state_t        state;
    logic [7:0]       shift;
    logic [2:0]       bit_cnt;
    logic             parity_bit;
    logic [TMR_W-1:0] timer;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    assign fall_c = clk_s3 & ~clk_s2;

    // Frame FSM; the idle timer only runs mid-frame and aborts silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RX_IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            parity_bit <= 1'b0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            err_strobe <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            err_strobe <= 1'b0;

            if (state != RX_IDLE && !fall_c) begin
                if (timer == TMR_LAST) begin
                    state <= RX_IDLE;
                    timer <= '0;
                end else begin
                    timer <= timer + TMR_W'(1);
                end
            end else begin
                timer <= '0;
            end

            if (fall_c) begin
                case (state)
                    RX_IDLE: begin
                        if (!data_s2) begin
                            state   <= RX_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        parity_bit <= data_s2;
                        state      <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (odd_parity_ok(shift, parity_bit) && data_s2) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            err_strobe <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_io.sv
// PS/2 keyboard io peripheral: scancode FIFO with DATA/STATUS registers.
module ps2_key_io
    import io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'hFFF0,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        wenable,
    input  logic [15:0] raddr,
    output logic [15:0] rdata,
    output logic        key_ready
);

    localparam int unsigned      PTR_W       = $clog2(FIFO_DEPTH);
    localparam int unsigned      CNT_W       = PTR_W + 1;
    localparam logic [15:0]      DATA_ADDR   = BASE_ADDR + 16'(REG_DATA_OFS);
    localparam logic [15:0]      STATUS_ADDR = BASE_ADDR + 16'(REG_STATUS_OFS);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);

    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_err;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             err, overflow;

    logic             pop_wr_c, ctrl_wr_c, flush_c, clr_ovf_c, clr_err_c;
    logic             empty_c, full_c, do_pop_c, do_push_c, ovf_set_c;
    logic [CNT_W-1:0] count_next_c;
    logic [15:0]      status_c;
    logic             wdata_unused_c;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (rx_valid),
        .byte_data  (rx_byte),
        .err_strobe (rx_err)
    );

    assign wdata_unused_c = ^{wdata[15:4], wdata[1]};

    // Write decode and FIFO push/pop arbitration; flush overrides everything.
    always_comb begin
        pop_wr_c     = 1'b0;
        ctrl_wr_c    = 1'b0;
        flush_c      = 1'b0;
        clr_ovf_c    = 1'b0;
        clr_err_c    = 1'b0;
        empty_c      = (count == '0);
        full_c       = (count == CNT_FULL);
        do_pop_c     = 1'b0;
        do_push_c    = 1'b0;
        ovf_set_c    = 1'b0;
        count_next_c = count;

        pop_wr_c  = wenable && (waddr == DATA_ADDR);
        ctrl_wr_c = wenable && (waddr == STATUS_ADDR);
        flush_c   = ctrl_wr_c && wdata[CTRL_FLUSH];
        clr_ovf_c = ctrl_wr_c && wdata[CTRL_CLR_OVF];
        clr_err_c = ctrl_wr_c && wdata[CTRL_CLR_ERR];

        do_pop_c  = pop_wr_c && !empty_c && !flush_c;
        do_push_c = rx_valid && !flush_c && (!full_c || do_pop_c);
        ovf_set_c = rx_valid && !flush_c && full_c && !do_pop_c;

        if (flush_c) begin
            count_next_c = '0;
        end else if (do_push_c && !do_pop_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy; key_ready tracks the next count to save a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            key_ready <= 1'b0;
        end else begin
            if (flush_c) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_push_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
            count     <= count_next_c;
            key_ready <= (count_next_c != '0);
        end
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clock) begin
        if (do_push_c) begin
            fifo_mem[wr_ptr] <= rx_byte;
        end
    end

    // Sticky status bits; a set in the same cycle as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            err      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            err      <= (err & ~clr_err_c) | rx_err;
            overflow <= (overflow & ~clr_ovf_c) | ovf_set_c;
        end
    end

    // STATUS word assembly.
    always_comb begin
        status_c              = 16'h0000;
        status_c[ST_NONEMPTY] = !empty_c;
        status_c[ST_FULL]     = full_c;
        status_c[ST_OVERFLOW] = overflow;
        status_c[ST_ERR]      = err;
    end

    // Registered, side-effect-free read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= 16'h0000;
        end else if (raddr == DATA_ADDR) begin
            rdata <= empty_c ? 16'h0000 : {8'h00, fifo_mem[rd_ptr]};
        end else if (raddr == STATUS_ADDR) begin
            rdata <= status_c;
        end else begin
            rdata <= 16'h0000;
        end
    end

endmodule
